par_bus_target: RTL

PAR_BUS_TARGET -- requirements
Module: par_bus_target

---
 rtl/par_bus_pkg.sv | 18 +
 rtl/par_bus_if.sv | 30 +++
 rtl/par_bus_fifo.sv | 60 ++++++
 rtl/par_bus_target.sv | 108 ++++++++++
 4 files changed

// File: rtl/par_bus_pkg.sv
// Shared command encoding and error classification for the parallel bus target.
package par_bus_pkg;

  localparam int CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    NOP   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RSVD  = 2'd3
  } bus_cmd_e;

  // RSVD is always an error; READ/WRITE only when the address misses storage.
  function automatic logic cmd_is_err(input bus_cmd_e cmd, input logic in_range);
    return (cmd == RSVD) || (((cmd == READ) || (cmd == WRITE)) && !in_range);
  endfunction

endpackage

// File: rtl/par_bus_if.sv
// Request/response bus between an initiator (master) and par_bus_target (slave).
interface par_bus_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) ();
  import par_bus_pkg::*;

  logic              req_valid;
  logic              req_ready;
  bus_cmd_e          req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output req_valid, req_cmd, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err, err_count
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err, err_count
  );

endinterface

// File: rtl/par_bus_fifo.sv
// Request queue: registered storage, so a pushed entry reaches the head one edge later.
module par_bus_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [WIDTH-1:0] store_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  // Full is purely occupancy-based; a same-cycle pop never frees a slot early.
  assign full      = (count_q == DEPTH_CNT);
  assign empty     = (count_q == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = store_q[rd_ptr_q];

  always_comb begin
    store_d  = store_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      store_d[wr_ptr_q] = push_data;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q  <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      store_q  <= store_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/par_bus_target.sv
// Memory-backed bus target: queued requests, word storage, one held read response.
module par_bus_target
  import par_bus_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int MEM_DEPTH  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input logic      clk,
  input logic      rst,
  par_bus_if.slave bus
);
  localparam int ENTRY_W = CMD_W + ADDR_W + DATA_W;
  localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_DEPTH);

  logic [ENTRY_W-1:0] head;
  logic               fifo_full, fifo_empty, pop;
  bus_cmd_e           head_cmd;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_wdata;
  logic               in_range;
  logic [IDX_W-1:0]   mem_idx;

  logic [DATA_W-1:0]  mem_q [MEM_DEPTH];
  logic [DATA_W-1:0]  mem_d [MEM_DEPTH];
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;

  par_bus_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.req_valid),
    .push_data({bus.req_cmd, bus.req_addr, bus.req_data}),
    .pop      (pop),
    .head_data(head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign head_cmd   = bus_cmd_e'(head[ENTRY_W-1 -: CMD_W]);
  assign head_addr  = head[DATA_W +: ADDR_W];
  assign head_wdata = head[DATA_W-1:0];
  assign in_range   = ({1'b0, head_addr} < MEM_LIMIT);
  assign mem_idx    = head_addr[IDX_W-1:0];

  // Only a READ needs the response slot; it may reuse it on the handshake edge.
  assign pop = !fifo_empty && ((head_cmd != READ) || !rsp_valid_q || bus.rsp_ready);

  always_comb begin
    mem_d       = mem_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    err_count_d = err_count_q;
    if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    if (pop) begin
      unique case (head_cmd)
        READ: begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = in_range ? mem_q[mem_idx] : '0;
          rsp_err_d   = !in_range;
        end
        WRITE: begin
          if (in_range) begin
            mem_d[mem_idx] = head_wdata;
          end
        end
        default: ;
      endcase
      if (cmd_is_err(head_cmd, in_range) && (err_count_q != '1)) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q       <= '{default: '0};
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      mem_q       <= mem_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.req_ready = !fifo_full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.err_count = err_count_q;

endmodule
